// File: rtl/hilo_muldiv.sv
// -----------------------------------------------------------------------------
// hilo_muldiv
//   Multi-cycle multiply/divide unit together with the architectural HI/LO
//   registers, evaluated in the EX stage. While a result is being produced the
//   unit raises div_mul_stall so the pipeline holds IF/ID/EX. HI/LO are
//   committed only when the EX instruction advances (ex_ready) and has not
//   been squashed (flush).
//
//   Operations: MULT/MULTU/DIV/DIVU (multi-cycle), MTHI/MTLO (single cycle,
//   no stall). MFHI/MFLO simply read the hi/lo outputs.
//
//   Optional build macro:
//     DIVMUL_FAST_EN - a divide by zero, or one with |a| < |b|, skips the
//                      iterative phase and goes straight to DONE.
//
// Parameters
//   MUL_LAT        multiply latency in cycles after the product is registered
//                  (legal range 1..8)
//
// Ports
//   clk            clock
//   resetn         asynchronous active-low reset
//   ex_mult        EX holds MULT   (the six ex_* op flags are mutually
//   ex_multu       EX holds MULTU   exclusive)
//   ex_div         EX holds DIV
//   ex_divu        EX holds DIVU
//   ex_mthi        EX holds MTHI
//   ex_mtlo        EX holds MTLO
//   ex_a           rs value (dividend / multiplicand / MTHI-MTLO data)
//   ex_b           rt value (divisor / multiplier)
//   ex_ready       EX instruction advances to EC this cycle
//   flush          exception or ERET squash
//   div_mul_stall  hold the pipeline, result not ready yet
//   busy           unit is not idle
//   hi, lo         architectural HI/LO registers
// -----------------------------------------------------------------------------
module hilo_muldiv #(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ex_mult,
    input  logic        ex_multu,
    input  logic        ex_div,
    input  logic        ex_divu,
    input  logic        ex_mthi,
    input  logic        ex_mtlo,
    input  logic [31:0] ex_a,
    input  logic [31:0] ex_b,
    input  logic        ex_ready,
    input  logic        flush,
    output logic        div_mul_stall,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL_RUN = 2'd1,
        DIV_RUN = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [5:0] MUL_LAST = 6'(MUL_LAT - 1);
    localparam logic [5:0] DIV_LAST = 6'd31;

    state_t      state;
    logic [5:0]  cnt;
    logic        is_div;
    logic        q_neg;      // quotient sign: operand signs differ
    logic        r_neg;      // remainder sign follows the dividend
    logic [63:0] prod;
    logic [31:0] quo;        // holds remaining dividend bits, fills with quotient bits
    logic [31:0] rem;
    logic [31:0] dsr;

    // ---------------------------------------------------------------- operand prep
    logic        op;
    logic        op_signed;
    logic        op_is_div;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] mul_full;

    assign op        = ex_mult | ex_multu | ex_div | ex_divu;
    assign op_signed = ex_mult | ex_div;
    assign op_is_div = ex_div | ex_divu;
    assign a_neg     = op_signed & ex_a[31];
    assign b_neg     = op_signed & ex_b[31];

    // Magnitudes are unsigned 32-bit values: negating 0x80000000 gives
    // 0x80000000, which is exactly |-2^31|, so no 33rd bit is needed here.
    assign a_mag = a_neg ? (~ex_a + 32'd1) : ex_a;
    assign b_mag = b_neg ? (~ex_b + 32'd1) : ex_b;

    // Sign- or zero-extend to 64 bits; the low 64 bits of the product are then
    // exact for both signed and unsigned operands.
    assign mul_a    = {{32{a_neg}}, ex_a};
    assign mul_b    = {{32{b_neg}}, ex_b};
    assign mul_full = mul_a * mul_b;

    // ---------------------------------------------------------------- divide step
    // One restoring iteration: shift the next dividend bit into the partial
    // remainder, then subtract the divisor if it fits. The shifted remainder
    // is 33 bits wide so a divisor with bit 31 set compares correctly.
    logic [32:0] r_shift;
    logic        sub_ok;
    logic [31:0] r_diff;

    assign r_shift = {rem, quo[31]};
    assign sub_ok  = r_shift >= {1'b0, dsr};
    assign r_diff  = r_shift[31:0] - dsr;

    // ---------------------------------------------------------------- early-out
    logic div_skip;
`ifdef DIVMUL_FAST_EN
    assign div_skip = (ex_b == 32'd0) || (a_mag < b_mag);
`else
    assign div_skip = 1'b0;
`endif

    // ---------------------------------------------------------------- result
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    // NOTE: every path assigns both outputs, so this block stays purely
    // combinational and no latch is inferred.
    always_comb begin
        if (is_div) begin
            res_hi = r_neg ? (~rem + 32'd1) : rem;
            res_lo = q_neg ? (~quo + 32'd1) : quo;
        end else begin
            res_hi = prod[63:32];
            res_lo = prod[31:0];
        end
    end

    // Reset also forces the stall low, so the pipeline is never held while
    // the unit is in reset.
    assign div_mul_stall = resetn && !flush &&
                           ((state == IDLE && op) || state == MUL_RUN || state == DIV_RUN);
    assign busy          = (state != IDLE);

    // ---------------------------------------------------------------- control
    // NOTE: all state is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            cnt    <= '0;
            is_div <= 1'b0;
            q_neg  <= 1'b0;
            r_neg  <= 1'b0;
            prod   <= '0;
            quo    <= '0;
            rem    <= '0;
            dsr    <= '0;
            hi     <= '0;
            lo     <= '0;
        end else if (flush) begin
            // Squash wins over commit and over a new start.
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (op) begin
                        cnt    <= '0;
                        is_div <= op_is_div;
                        if (op_is_div) begin
                            q_neg <= a_neg ^ b_neg;
                            r_neg <= a_neg;
                            dsr   <= b_mag;
                            if (div_skip) begin
                                // Divide by zero yields an all-ones raw quotient,
                                // |a| < |b| yields zero; the raw remainder is |a|.
                                quo   <= (ex_b == 32'd0) ? 32'hFFFF_FFFF : 32'd0;
                                rem   <= a_mag;
                                state <= DONE;
                            end else begin
                                quo   <= a_mag;
                                rem   <= '0;
                                state <= DIV_RUN;
                            end
                        end else begin
                            prod  <= mul_full;
                            state <= MUL_RUN;
                        end
                    end else if (ex_ready) begin
                        if (ex_mthi) hi <= ex_a;
                        if (ex_mtlo) lo <= ex_a;
                    end
                end

                MUL_RUN: begin
                    if (cnt == MUL_LAST) state <= DONE;
                    else                 cnt   <= cnt + 6'd1;
                end

                DIV_RUN: begin
                    rem <= sub_ok ? r_diff : r_shift[31:0];
                    quo <= {quo[30:0], sub_ok};
                    if (cnt == DIV_LAST) state <= DONE;
                    else                 cnt   <= cnt + 6'd1;
                end

                DONE: begin
                    // Hold the result until the instruction actually advances.
                    if (ex_ready) begin
                        hi    <= res_hi;
                        lo    <= res_lo;
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv.sv
// -----------------------------------------------------------------------------
// tb_hilo_muldiv
//   Self-checking bench for hilo_muldiv. A behavioural model (operation
//   results from plain integer arithmetic, timing as a countdown of remaining
//   busy cycles) is compared against the DUT on every falling clock edge.
//   Directed operations with hand-computed results pin the model, followed by
//   randomized traffic including random flushes.
// -----------------------------------------------------------------------------
module tb_hilo_muldiv;

    localparam int MUL_LAT = 2;
`ifdef DIVMUL_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    localparam int K_MULT  = 0;
    localparam int K_MULTU = 1;
    localparam int K_DIV   = 2;
    localparam int K_DIVU  = 3;
    localparam int K_MTHI  = 4;
    localparam int K_MTLO  = 5;
    localparam int K_NONE  = 6;

    logic        clk;
    logic        resetn;
    logic        ex_mult;
    logic        ex_multu;
    logic        ex_div;
    logic        ex_divu;
    logic        ex_mthi;
    logic        ex_mtlo;
    logic [31:0] ex_a;
    logic [31:0] ex_b;
    logic        ex_ready;
    logic        flush;
    logic        div_mul_stall;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;

    hilo_muldiv #(.MUL_LAT(MUL_LAT)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .ex_mult      (ex_mult),
        .ex_multu     (ex_multu),
        .ex_div       (ex_div),
        .ex_divu      (ex_divu),
        .ex_mthi      (ex_mthi),
        .ex_mtlo      (ex_mtlo),
        .ex_a         (ex_a),
        .ex_b         (ex_b),
        .ex_ready     (ex_ready),
        .flush        (flush),
        .div_mul_stall(div_mul_stall),
        .busy         (busy),
        .hi           (hi),
        .lo           (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------ check helper
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------ reference math
    function automatic logic [63:0] ref_result(input logic m, input logic mu, input logic d,
                                               input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic [63:0] ua, ub, q, r;
        logic an, bn;
        if (m) begin
            sa = 64'($signed(a));
            sb = 64'($signed(b));
            return 64'(sa * sb);
        end
        if (mu) begin
            ua = {32'd0, a};
            ub = {32'd0, b};
            return ua * ub;
        end
        an = d && a[31];
        bn = d && b[31];
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (an) ua = 64'h1_0000_0000 - ua;
        if (bn) ub = 64'h1_0000_0000 - ub;
        if (ub == 64'd0) begin
            q = 64'hFFFF_FFFF;
            r = ua;
        end else begin
            q = ua / ub;
            r = ua % ub;
        end
        if (an ^ bn) q = -q;
        if (an)      r = -r;
        return {r[31:0], q[31:0]};
    endfunction

    // Busy cycles after the start cycle before the result is available.
    function automatic int op_latency(input logic is_div_op, input logic sgn,
                                      input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ua, ub;
        if (!is_div_op) return MUL_LAT;
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (sgn && a[31]) ua = 64'h1_0000_0000 - ua;
        if (sgn && b[31]) ub = 64'h1_0000_0000 - ub;
        if (FAST && (ub == 64'd0 || ua < ub)) return 0;
        return 32;
    endfunction

    // ------------------------------------------------------------ behavioural model
    typedef enum {P_IDLE, P_RUN, P_DONE} phase_t;

    phase_t      m_phase;
    int          m_left;
    logic [63:0] m_res;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    wire op_now = ex_mult | ex_multu | ex_div | ex_divu;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_phase <= P_IDLE;
            m_left  <= 0;
            m_res   <= '0;
            m_hi    <= '0;
            m_lo    <= '0;
        end else if (flush) begin
            m_phase <= P_IDLE;
            m_left  <= 0;
        end else begin
            case (m_phase)
                P_IDLE: begin
                    if (op_now) begin
                        m_res <= ref_result(ex_mult, ex_multu, ex_div, ex_a, ex_b);
                        if (op_latency(ex_div | ex_divu, ex_mult | ex_div, ex_a, ex_b) == 0) begin
                            m_phase <= P_DONE;
                        end else begin
                            m_phase <= P_RUN;
                            m_left  <= op_latency(ex_div | ex_divu, ex_mult | ex_div, ex_a, ex_b);
                        end
                    end else if (ex_ready && ex_mthi) begin
                        m_hi <= ex_a;
                    end else if (ex_ready && ex_mtlo) begin
                        m_lo <= ex_a;
                    end
                end
                P_RUN: begin
                    if (m_left == 1) m_phase <= P_DONE;
                    m_left <= m_left - 1;
                end
                P_DONE: begin
                    if (ex_ready) begin
                        m_hi    <= m_res[63:32];
                        m_lo    <= m_res[31:0];
                        m_phase <= P_IDLE;
                    end
                end
                default: m_phase <= P_IDLE;
            endcase
        end
    end

    wire exp_stall = resetn && !flush && ((m_phase == P_IDLE && op_now) || m_phase == P_RUN);
    wire exp_busy  = (m_phase != P_IDLE);

    // Every-cycle comparison, away from the rising edge.
    always @(negedge clk) begin
        check("stall", {63'd0, div_mul_stall}, {63'd0, exp_stall});
        check("busy",  {63'd0, busy},          {63'd0, exp_busy});
        check("hi",    {32'd0, hi},            {32'd0, m_hi});
        check("lo",    {32'd0, lo},            {32'd0, m_lo});
    end

    // ------------------------------------------------------------ stimulus helpers
    task automatic set_kind(input int k);
        ex_mult  = (k == K_MULT);
        ex_multu = (k == K_MULTU);
        ex_div   = (k == K_DIV);
        ex_divu  = (k == K_DIVU);
        ex_mthi  = (k == K_MTHI);
        ex_mtlo  = (k == K_MTLO);
    endtask

    task automatic idle_inputs();
        set_kind(K_NONE);
        ex_a     = '0;
        ex_b     = '0;
        ex_ready = 1'b1;
        flush    = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Run one mul/div op: wait for DONE, hold ex_ready low for 'hold' cycles,
    // then either advance (ex_ready) or squash (flush). Returns the number of
    // cycles in which the DUT stalled.
    task automatic do_op(input int k, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input bit squash, output int stalls);
        set_kind(k);
        ex_a     = a;
        ex_b     = b;
        ex_ready = 1'b0;
        flush    = 1'b0;
        stalls   = 0;
        for (int i = 0; i < 60 && m_phase != P_DONE; i++) begin
            @(negedge clk);
            if (div_mul_stall) stalls++;
            step();
        end
        if (m_phase != P_DONE) begin
            total++;
            bad++;
            $display("FAIL op_timeout: kind %0d never reached done", k);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (div_mul_stall) stalls++;
            step();
        end
        if (squash) flush = 1'b1;
        else        ex_ready = 1'b1;
        @(negedge clk);
        if (div_mul_stall) stalls++;
        step();
        idle_inputs();
    endtask

    task automatic mt_op(input bit to_hi, input logic [31:0] data, input bit fl, output int stalls);
        set_kind(to_hi ? K_MTHI : K_MTLO);
        ex_a     = data;
        ex_ready = 1'b1;
        flush    = fl;
        @(negedge clk);
        stalls = int'(div_mul_stall);
        step();
        idle_inputs();
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            5:       return 32'($urandom_range(0, 255));
            default: return $urandom();
        endcase
    endfunction

    // ------------------------------------------------------------ watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------ main sequence
    initial begin
        int n;
        int k;
        resetn = 1'b0;
        idle_inputs();
        repeat (3) step();

        check("reset hi",    {32'd0, hi},   64'd0);
        check("reset lo",    {32'd0, lo},   64'd0);
        check("reset stall", {63'd0, div_mul_stall}, 64'd0);
        check("reset busy",  {63'd0, busy}, 64'd0);

        resetn = 1'b1;
        step();

        // Unsigned divide: 100 / 7 = 14 r 2, full 32 iterations.
        do_op(K_DIVU, 32'd100, 32'd7, 0, 1'b0, n);
        check("divu100_7 stalls", 64'(n), 64'd33);
        check("divu100_7", {hi, lo}, {32'd2, 32'd14});

        // Signed divide: -7 / 2 = -3 r -1.
        do_op(K_DIV, 32'hFFFF_FFF9, 32'd2, 0, 1'b0, n);
        check("div_m7_2", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

        // Overflow case: -2^31 / -1 wraps to -2^31 r 0.
        do_op(K_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, n);
        check("div_ovf", {hi, lo}, {32'h0, 32'h8000_0000});

        // Multiplies.
        do_op(K_MULT, 32'hFFFF_FFFF, 32'd2, 0, 1'b0, n);
        check("mult stalls", 64'(n), 64'(MUL_LAT + 1));
        check("mult_m1_2", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFE});
        do_op(K_MULTU, 32'hFFFF_FFFF, 32'd2, 0, 1'b0, n);
        check("multu_ff_2", {hi, lo}, {32'h0000_0001, 32'hFFFF_FFFE});

        // Result held in DONE for 4 cycles with no stall, then committed.
        do_op(K_DIVU, 32'd1000, 32'd3, 4, 1'b0, n);
        check("hold stalls", 64'(n), 64'd33);
        check("divu1000_3", {hi, lo}, {32'd1, 32'd333});

        // Flush in DONE: no write, back to idle.
        do_op(K_DIVU, 32'd50, 32'd5, 2, 1'b1, n);
        check("flush_done hilo", {hi, lo}, {32'd1, 32'd333});
        check("flush_done busy", {63'd0, busy}, 64'd0);

        // MTLO squashed, then MTLO and MTHI taken; none stall.
        mt_op(1'b0, 32'h1234_5678, 1'b1, n);
        check("mtlo_flush lo", {32'd0, lo}, {32'd0, 32'd333});
        mt_op(1'b0, 32'h1234_5678, 1'b0, n);
        check("mtlo lo", {32'd0, lo}, {32'd0, 32'h1234_5678});
        check("mtlo stall", 64'(n), 64'd0);
        mt_op(1'b1, 32'hCAFE_F00D, 1'b0, n);
        check("mthi hi", {32'd0, hi}, {32'd0, 32'hCAFE_F00D});

        // Divide by zero, unsigned and signed.
        do_op(K_DIVU, 32'd5, 32'd0, 0, 1'b0, n);
        check("divu5_0 stalls", 64'(n), FAST ? 64'd1 : 64'd33);
        check("divu5_0", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
        do_op(K_DIV, 32'hFFFF_FFFB, 32'd0, 0, 1'b0, n);
        check("div_m5_0", {hi, lo}, {32'hFFFF_FFFB, 32'h0000_0001});

        // Dividend smaller than divisor.
        do_op(K_DIVU, 32'd3, 32'd9, 0, 1'b0, n);
        check("divu3_9 stalls", 64'(n), FAST ? 64'd1 : 64'd33);
        check("divu3_9", {hi, lo}, {32'd3, 32'd0});

        // Asynchronous reset in the middle of a divide.
        set_kind(K_DIVU);
        ex_a     = 32'h0000_DEAD;
        ex_b     = 32'd3;
        ex_ready = 1'b0;
        repeat (10) step();
        resetn = 1'b0;
        #1;
        check("midreset hi",    {32'd0, hi},   64'd0);
        check("midreset lo",    {32'd0, lo},   64'd0);
        check("midreset stall", {63'd0, div_mul_stall}, 64'd0);
        check("midreset busy",  {63'd0, busy}, 64'd0);
        idle_inputs();
        step();
        resetn = 1'b1;
        step();

        // Randomized traffic; the every-cycle comparison does the checking.
        for (int c = 0; c < 3000; c++) begin
            if (m_phase == P_IDLE) begin
                k = $urandom_range(0, 7);
                set_kind(k > K_MTLO ? K_NONE : k);
                ex_a     = rnd_operand();
                ex_b     = rnd_operand();
                ex_ready = ($urandom_range(0, 3) != 0);
            end else if (m_phase == P_DONE) begin
                ex_ready = $urandom_range(0, 1) == 1;
            end else begin
                ex_ready = 1'b0;
            end
            flush = ($urandom_range(0, 39) == 0);
            step();
        end

        idle_inputs();
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv.md
Name: hilo_muldiv

Overview:
- Multi-cycle multiply/divide unit plus the architectural HI/LO registers, evaluated in the EX stage.
- Drives div_mul_stall into the pipeline control unit, which holds IF/ID/EX and bubbles EX→EC while the stall is high.
- Commits HI/LO only when the EX instruction advances and has not been flushed.
- Serves MULT/MULTU/DIV/DIVU/MTHI/MTLO; MFHI/MFLO read the hi/lo outputs.

Parameters:
MUL_LAT, 2, multiply latency in cycles (legal range 1..8), implemented as a counted delay after the product is registered.

Ports:
clk  in  1  clock
resetn  in  1  reset; asynchronous, active-low
ex_mult  in  1  EX holds MULT (ex_mult/ex_multu/ex_div/ex_divu/ex_mthi/ex_mtlo are mutually exclusive)
ex_multu  in  1  EX holds MULTU
ex_div  in  1  EX holds DIV
ex_divu  in  1  EX holds DIVU
ex_mthi  in  1  EX holds MTHI
ex_mtlo  in  1  EX holds MTLO
ex_a  in  32  rs value (dividend / multiplicand / MTHI-MTLO data)
ex_b  in  32  rt value (divisor / multiplier)
ex_ready  in  1  EX instruction advances to EC this cycle (= !ex_ec_stall)
flush  in  1  exception or ERET squash (exc_oc || eret)
div_mul_stall  out  1  hold pipeline; result not ready
busy  out  1  state != IDLE
hi  out  32  HI register
lo  out  32  LO register

Behaviour:
- Reset (async, resetn=0): state=IDLE, hi=0, lo=0, counters=0, div_mul_stall=0, busy=0.
- States: IDLE, MUL_RUN, DIV_RUN, DONE. op = ex_mult|ex_multu|ex_div|ex_divu.
- div_mul_stall (combinational) = !flush && ((state==IDLE && op) || state==MUL_RUN || state==DIV_RUN). It is 0 in DONE.
- IDLE, op && !flush:
  - Latch operands and signedness.
  - Divide: latch |a|, |b| (magnitudes when signed) and the sign flags; go to DIV_RUN with cnt=0.
  - Multiply: register the 64-bit product (signed or unsigned); go to MUL_RUN with cnt=0.
- DIV_RUN: one restoring iteration per cycle (shift remainder, trial subtract, set quotient bit). After the 32nd iteration (cnt==31), go to DONE. Sign fix-up is applied combinationally in DONE:
  - quotient is negated if signs differ;
  - remainder takes the dividend's sign.
- MUL_RUN: count MUL_LAT cycles, then go to DONE.
- Latency, with the op first seen in cycle N:
  - divide: stall high N..N+32, DONE at N+33;
  - multiply: stall high N..N+MUL_LAT, DONE at N+MUL_LAT+1.
- DONE:
  - ex_ready && !flush: write {hi,lo} at the clock edge (mul: hi=prod[63:32], lo=prod[31:0]; div: hi=remainder, lo=quotient); go to IDLE.
  - !ex_ready: hold DONE and the result; stall stays 0.
- Divide by zero: still runs the full 32 iterations. Unsigned result: lo=0xFFFFFFFF, hi=a. Signed result: apply the normal sign fix-up to those raw values.
- 0x80000000 / 0xFFFFFFFF signed: lo=0x80000000, hi=0. The magnitude path must be 33-bit safe.
- MTHI/MTLO: in IDLE with ex_ready && !flush, hi<=ex_a or lo<=ex_a at the edge, with no stall. These are ignored if state != IDLE (cannot occur legally).
- flush in any state: next state=IDLE, no HI/LO write, counters cleared. Flush has priority over DONE commit and over a new start in the same cycle.
- A new op in the cycle right after DONE→IDLE starts normally; there are no back-to-back bubbles beyond the one IDLE start cycle.

Optional Feature:
- Macro: DIVMUL_FAST_EN.
- Defined: in IDLE, a divide with b==0, or with |a| < |b|, goes directly to DONE with no iterations. Result is q=0, r=a for |a|<|b|, and the divide-by-zero values for b==0. Stall is high only in cycle N; DONE at N+1.
- Undefined: every divide takes the full 32 iterations.

Test Plan:
- Reset mid-DIV_RUN: assert resetn=0 at cycle N+10 → hi=lo=0 immediately, state IDLE, stall=0.
- DIVU a=100, b=7, ex_ready=1 → stall high exactly 33 cycles, then hi=2, lo=14.
- DIV a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- MULT a=0xFFFFFFFF, b=2, MUL_LAT=2 → stall 3 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE. MULTU with the same operands → hi=0x00000001, lo=0xFFFFFFFE.
- DONE with ex_ready=0 for 4 cycles, then 1 → hi/lo unchanged until the ex_ready cycle; stall=0 throughout DONE. Flush asserted in DONE instead → no write, IDLE.
- MTLO a=0x12345678 with flush=1 → lo unchanged. With flush=0 → lo=0x12345678, stall never asserted. DIVU 5/0 → hi=5, lo=0xFFFFFFFF. With DIVMUL_FAST_EN, DIVU 3/9 → hi=3, lo=0, stall high 1 cycle.
